// File: rtl/uart_rx_fifo.sv
// UART receive FIFO: synchronised save strobe, show-ahead read port.
// Optional drop counter: define UART_RX_FIFO_DROP_CNT_EN.
module uart_rx_fifo #(
  parameter int DEPTH = 8,
  parameter int n     = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [n-1:0]               data_i,
  input  logic                       save_i,
  input  logic                       clr_i,
  input  logic                       ready_i,
  output logic [n-1:0]               data_o,
  output logic                       valid_o,
  output logic                       full_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       ovf_o,
  output logic [7:0]                 drop_cnt_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [2:0]    sync_q;
  logic [2:0]    prime_q;
  logic [AW-1:0] wp_q, wp_d;
  logic [AW-1:0] rp_q, rp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic [n-1:0]  mem_q [DEPTH];

  logic push, pop, push_ok, drop;

  // prime_q marks sync stages holding real samples, so a level
  // already high at reset release is not seen as a rising edge
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      sync_q  <= '0;
      prime_q <= '0;
    end else begin
      sync_q  <= {sync_q[1:0], save_i};
      prime_q <= {prime_q[1:0], 1'b1};
    end
  end

  assign push    = sync_q[1] & ~sync_q[2] & prime_q[2];
  assign valid_o = (cnt_q != '0);
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign pop     = valid_o & ready_i & ~clr_i;
  assign push_ok = push & ~clr_i & (~full_o | pop);
  assign drop    = push & ~clr_i & full_o & ~pop;

  always_comb begin
    wp_d  = wp_q;
    rp_d  = rp_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q | drop;
    if (clr_i) begin
      wp_d  = '0;
      rp_d  = '0;
      cnt_d = '0;
      ovf_d = 1'b0;
    end else begin
      if (push_ok) wp_d = wp_q + 1'b1;
      if (pop)     rp_d = rp_q + 1'b1;
      case ({push_ok, pop})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  // storage is deliberately left unreset
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wp_q] <= data_i;
  end

  assign data_o  = mem_q[rp_q];
  assign count_o = cnt_q;
  assign ovf_o   = ovf_q;

`ifdef UART_RX_FIFO_DROP_CNT_EN
  logic [7:0] drop_q, drop_d;

  always_comb begin
    drop_d = drop_q;
    if (clr_i)
      drop_d = '0;
    else if (drop && drop_q != 8'hFF)
      drop_d = drop_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) drop_q <= '0;
    else        drop_q <= drop_d;
  end

  assign drop_cnt_o = drop_q;
`else
  assign drop_cnt_o = '0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo with a scoreboard queue.
module tb_uart_rx_fifo;

  localparam int DEPTH = 8;
  localparam int N     = 8;
`ifdef UART_RX_FIFO_DROP_CNT_EN
  localparam logic [7:0] EXP_DROP = 8'd1;
`else
  localparam logic [7:0] EXP_DROP = 8'd0;
`endif

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic [N-1:0] data_i;
  logic         save_i;
  logic         clr_i;
  logic         ready_i;
  logic [N-1:0] data_o;
  logic         valid_o;
  logic         full_o;
  logic [3:0]   count_o;
  logic         ovf_o;
  logic [7:0]   drop_cnt_o;

  int n_cmp = 0;
  int n_err = 0;
  logic [N-1:0] exp_q [$];

  uart_rx_fifo #(.DEPTH(DEPTH), .n(N)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .data_i     (data_i),
    .save_i     (save_i),
    .clr_i      (clr_i),
    .ready_i    (ready_i),
    .data_o     (data_o),
    .valid_o    (valid_o),
    .full_o     (full_o),
    .count_o    (count_o),
    .ovf_o      (ovf_o),
    .drop_cnt_o (drop_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int k);
    repeat (k) @(posedge clk_i);
    #1;
  endtask

  task automatic send(input logic [N-1:0] b, input bit acc);
    data_i = b;
    save_i = 1'b1;
    if (acc) exp_q.push_back(b);
    tick(3);
    save_i = 1'b0;
    tick(3);
  endtask

  task automatic drain();
    ready_i = 1'b1;
    tick(DEPTH + 4);
    ready_i = 1'b0;
    chk("drain_valid", valid_o, 0);
    chk("drain_sb", exp_q.size(), 0);
  endtask

  // a pop happens at the next edge whenever valid&ready is seen here
  always @(negedge clk_i) begin
    if (rst_i && valid_o && ready_i) begin
      if (exp_q.size() == 0)
        chk("unexp_pop", data_o, 32'hFFFF_FFFF);
      else
        chk("pop_data", data_o, exp_q.pop_front());
    end
  end

  initial begin
    rst_i   = 1'b0;
    data_i  = '0;
    save_i  = 1'b0;
    clr_i   = 1'b0;
    ready_i = 1'b0;
    tick(2);
    chk("rst_valid", valid_o, 0);
    chk("rst_full", full_o, 0);
    chk("rst_count", count_o, 0);
    chk("rst_ovf", ovf_o, 0);
    chk("rst_drop", drop_cnt_o, 0);
    rst_i = 1'b1;
    tick(4);

    // first byte latency
    data_i = 8'hA5;
    save_i = 1'b1;
    exp_q.push_back(8'hA5);
    tick(2);
    chk("lat_edge2_valid", valid_o, 0);
    tick(1);
    chk("lat_edge3_valid", valid_o, 1);
    chk("lat_edge3_data", data_o, 8'hA5);
    chk("lat_edge3_count", count_o, 1);
    save_i = 1'b0;
    tick(3);
    drain();

    // fill and read in order
    for (int i = 1; i <= 8; i++) begin
      send(8'(i), 1'b1);
      if (i == 7) chk("fill7_full", full_o, 0);
    end
    chk("fill_full", full_o, 1);
    chk("fill_count", count_o, 8);
    drain();
    chk("empty_full", full_o, 0);

    // overflow on push while full
    for (int i = 0; i < 8; i++) send(8'h11 + 8'(i), 1'b1);
    chk("pre_ovf", ovf_o, 0);
    send(8'h55, 1'b0);
    chk("ovf_set", ovf_o, 1);
    chk("ovf_count", count_o, 8);
    chk("ovf_drop", drop_cnt_o, EXP_DROP);
    drain();
    chk("ovf_sticky", ovf_o, 1);
    clr_i = 1'b1;
    tick(1);
    clr_i = 1'b0;
    chk("clr_ovf", ovf_o, 0);
    chk("clr_drop", drop_cnt_o, 0);

    // simultaneous push and pop while full
    for (int i = 0; i < 8; i++) send(8'h21 + 8'(i), 1'b1);
    data_i = 8'h77;
    save_i = 1'b1;
    exp_q.push_back(8'h77);
    tick(2);
    ready_i = 1'b1;
    tick(1);
    ready_i = 1'b0;
    chk("pp_count", count_o, 8);
    chk("pp_full", full_o, 1);
    chk("pp_ovf", ovf_o, 0);
    save_i = 1'b0;
    tick(3);
    drain();

    // long save level gives one push
    data_i = 8'h3C;
    save_i = 1'b1;
    exp_q.push_back(8'h3C);
    tick(20);
    save_i = 1'b0;
    tick(3);
    chk("long_count", count_o, 1);
    chk("long_data", data_o, 8'h3C);

    // clear coincident with a push strobe
    data_i = 8'h99;
    save_i = 1'b1;
    tick(2);
    clr_i = 1'b1;
    tick(1);
    clr_i = 1'b0;
    exp_q.delete();
    chk("clrp_count", count_o, 0);
    chk("clrp_valid", valid_o, 0);
    chk("clrp_ovf", ovf_o, 0);
    chk("clrp_drop", drop_cnt_o, 0);
    save_i = 1'b0;
    tick(4);
    chk("clrp_late", count_o, 0);

    // reset mid-read
    for (int i = 0; i < 5; i++) send(8'h41 + 8'(i), 1'b1);
    chk("mid_count", count_o, 5);
    data_i  = 8'hE7;
    save_i  = 1'b1;
    ready_i = 1'b1;
    #2;
    rst_i = 1'b0;
    #1;
    exp_q.delete();
    chk("mid_valid", valid_o, 0);
    chk("mid_full", full_o, 0);
    chk("mid_cnt", count_o, 0);
    chk("mid_ovf", ovf_o, 0);
    chk("mid_drop", drop_cnt_o, 0);
    tick(2);
    rst_i = 1'b1;
    tick(10);
    chk("rel_hi_count", count_o, 0);
    chk("rel_hi_valid", valid_o, 0);
    save_i = 1'b0;
    tick(3);
    send(8'h5A, 1'b1);
    tick(2);
    chk("rel_new_count", count_o, 0);
    chk("final_sb", exp_q.size(), 0);
    ready_i = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
